// File: rtl/s38584_sel_pkg.sv
// Shared constants, helpers and the default-width stage record for the
// s38584 select/capture bank family.
package s38584_sel_pkg;

  localparam logic [7:0] DEF_MATCH_VAL  = 8'h1C;
  localparam logic [7:0] DEF_MATCH_MASK = 8'hFF;
  localparam int         DEF_W          = 32'sd1;
  localparam int         DEF_CH_W       = 32'sd2;
  localparam int         DEF_SEL_W      = 32'sd8;

  function automatic int clog2(input int v);
    int r;
    int p;
    r = 32'sd0;
    p = 32'sd1;
    while (p < v) begin
      p = p * 32'sd2;
      r = r + 32'sd1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic [DEF_CH_W-1:0]  ch;
    logic [DEF_SEL_W-1:0] sel;
    logic [DEF_W-1:0]     gsrc;
  } sel_stage_t;

endpackage

// File: rtl/s38584_sel_capture_bank_if.sv
// Request bus of the capture bank: valid/ready plus target channel and select word.
interface s38584_sel_capture_bank_if #(
  parameter int CH_W  = 2,
  parameter int SEL_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [CH_W-1:0]  req_ch;
  logic [SEL_W-1:0] req_sel;

  modport master (output req_valid, output req_ch, output req_sel, input req_ready);
  modport slave  (input req_valid, input req_ch, input req_sel, output req_ready);
endinterface

// File: rtl/s38584_sel_decode.sv
// Combinational hold-match compare and gated source mux, shared by sibling cones.
module s38584_sel_decode
  import s38584_sel_pkg::*;
#(
  parameter int               W          = 1,
  parameter int               SEL_W      = 8,
  parameter int               N_SRC      = 4,
  parameter logic [SEL_W-1:0] MATCH_VAL  = SEL_W'(DEF_MATCH_VAL),
  parameter logic [SEL_W-1:0] MATCH_MASK = SEL_W'(DEF_MATCH_MASK)
) (
  input  logic [SEL_W-1:0]        i_cmp_sel,
  input  logic [clog2(N_SRC)-1:0] i_src_idx,
  input  logic [N_SRC*W-1:0]      i_src_data,
  input  logic [N_SRC-1:0]        i_src_gate,
  output logic                    o_match,
  output logic [W-1:0]            o_gsrc
);
  localparam int IDX_W = clog2(N_SRC);

  if (IDX_W > SEL_W) begin : g_bad_idx_w
    $error("s38584_sel_decode: source index needs more bits than the select word has");
  end

  assign o_match = ((i_cmp_sel & MATCH_MASK) == (MATCH_VAL & MATCH_MASK));

  // One-hot AND-OR mux: only the indexed source, qualified by its gate, survives.
  always_comb begin
    o_gsrc = {W{1'b0}};
    for (int s = 0; s < N_SRC; s++) begin
      o_gsrc = o_gsrc |
               (i_src_data[s*W +: W] & {W{i_src_gate[s] && (i_src_idx == IDX_W'(s))}});
    end
  end

endmodule

// File: rtl/s38584_sel_capture_bank.sv
// Bank of N_CH registered W-bit channels fed through a one-deep request stage,
// with hold/zero/capture commit rules, a serial scan chain and a commit counter.
module s38584_sel_capture_bank
  import s38584_sel_pkg::*;
#(
  parameter int               W          = 1,
  parameter int               N_CH       = 4,
  parameter int               SEL_W      = 8,
  parameter int               N_SRC      = 4,
  parameter logic [SEL_W-1:0] MATCH_VAL  = SEL_W'(DEF_MATCH_VAL),
  parameter logic [SEL_W-1:0] MATCH_MASK = SEL_W'(DEF_MATCH_MASK)
) (
  input  logic                       CK,
  input  logic                       RST,
  input  logic                       en,
  s38584_sel_capture_bank_if.slave   req,
  input  logic [N_SRC*W-1:0]         src_data,
  input  logic [N_SRC-1:0]           src_gate,
  input  logic                       scan_en,
  input  logic                       scan_in,
  output logic                       scan_out,
  output logic [N_CH*W-1:0]          q,
  output logic [15:0]                upd_cnt
);
  localparam int CH_W  = clog2(N_CH);
  localparam int IDX_W = clog2(N_SRC);
  localparam int Q_W   = N_CH * W;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [SEL_W-1:0] sel;
    logic [W-1:0]     gsrc;
  } stage_t;

  stage_t           r_stage;
  logic             r_stage_valid;
  logic [Q_W-1:0]   r_q;
  logic [15:0]      r_upd_cnt;

  logic             w_accept;
  logic             w_commit;
  logic             w_match;
  logic             w_hold;
  logic [W-1:0]     w_gsrc;
  logic [W-1:0]     w_cap;
  logic [Q_W-1:0]   w_q_next;

  // Scan freezes a full stage, so only an empty stage may accept while scanning.
  assign req.req_ready = !r_stage_valid || !scan_en;
  assign w_accept      = req.req_valid && req.req_ready;
  assign w_commit      = r_stage_valid && !scan_en;
  assign w_hold        = en && w_match;
  assign w_cap         = en ? r_stage.gsrc : {W{1'b0}};

  s38584_sel_decode #(
    .W          (W),
    .SEL_W      (SEL_W),
    .N_SRC      (N_SRC),
    .MATCH_VAL  (MATCH_VAL),
    .MATCH_MASK (MATCH_MASK)
  ) u_decode (
    .i_cmp_sel  (r_stage.sel),
    .i_src_idx  (req.req_sel[IDX_W-1:0]),
    .i_src_data (src_data),
    .i_src_gate (src_gate),
    .o_match    (w_match),
    .o_gsrc     (w_gsrc)
  );

  // Next channel contents: scan shift has priority, otherwise one-channel commit.
  always_comb begin
    w_q_next = r_q;
    if (scan_en) begin
      w_q_next = {r_q[Q_W-2:0], scan_in};
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (w_commit && !w_hold && (r_stage.ch == CH_W'(c))) begin
          w_q_next[c*W +: W] = w_cap;
        end else begin
          w_q_next[c*W +: W] = r_q[c*W +: W];
        end
      end
    end
  end

  // Channel registers and commit counter.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_q       <= {Q_W{1'b0}};
      r_upd_cnt <= 16'h0000;
    end else begin
      r_q <= w_q_next;
      if (w_commit) begin
        r_upd_cnt <= r_upd_cnt + 16'h0001;
      end else begin
        r_upd_cnt <= r_upd_cnt;
      end
    end
  end

  // Request stage: a new accept overwrites a committing entry in the same edge.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_stage_valid <= 1'b0;
      r_stage       <= '0;
    end else if (w_accept) begin
      r_stage_valid <= 1'b1;
      r_stage.ch    <= req.req_ch;
      r_stage.sel   <= req.req_sel;
      r_stage.gsrc  <= w_gsrc;
    end else if (w_commit) begin
      r_stage_valid <= 1'b0;
    end else begin
      r_stage_valid <= r_stage_valid;
    end
  end

  assign q        = r_q;
  assign upd_cnt  = r_upd_cnt;
  assign scan_out = r_q[Q_W-1];

endmodule
